// File: rtl/cache_data_array.sv
// cache_data_array
//   Cache data store of NUM_BLOCKS x WORDS_PER_BLOCK words of WORD_W bits,
//   with a registered CPU read port, a CPU single-word write port and a
//   line-fill engine that streams one block from the memory side.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     rd_en/rd_blk/rd_word         read request; rd_data/rd_valid one cycle later
//     wr_en/wr_blk/wr_word/wr_data CPU write (ignored while a fill is running)
//     fill_start/fill_blk          start a line fill into fill_blk
//     fill_valid/fill_data         fill beats, written to words 0..WPB-1 in order
//     fill_busy                    fill in progress
//     fill_done                    one-cycle pulse after the last beat is written
//
//   Optional build macro CACHE_DATA_ARRAY_PARITY_EN adds a per-word even
//   parity bit, the rd_perr output and the inj_perr test input.
module cache_data_array #(
  parameter int unsigned NUM_BLOCKS      = 128,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned WORD_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rd_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      rd_blk,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_word,
  output logic [WORD_W-1:0]                  rd_data,
  output logic                               rd_valid,
  input  logic                               wr_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      wr_blk,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] wr_word,
  input  logic [WORD_W-1:0]                  wr_data,
  input  logic                               fill_start,
  input  logic [$clog2(NUM_BLOCKS)-1:0]      fill_blk,
  input  logic                               fill_valid,
  input  logic [WORD_W-1:0]                  fill_data,
  output logic                               fill_busy,
  output logic                               fill_done
`ifdef CACHE_DATA_ARRAY_PARITY_EN
  ,
  input  logic                               inj_perr,
  output logic                               rd_perr
`endif
);

  localparam int unsigned BLK_W = $clog2(NUM_BLOCKS);
  localparam int unsigned OFS_W = $clog2(WORDS_PER_BLOCK);
`ifdef CACHE_DATA_ARRAY_PARITY_EN
  localparam int unsigned ENT_W = WORD_W + 1;
`else
  localparam int unsigned ENT_W = WORD_W;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(WORDS_PER_BLOCK - 1);

  logic [ENT_W-1:0]  mem_q [NUM_BLOCKS][WORDS_PER_BLOCK];

  logic [0:0]        state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [OFS_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
  logic              rd_perr_q;
`endif

  // Index range checks (constant-true when NUM_BLOCKS is a power of two)
  logic rd_in_range, wr_in_range, fill_in_range;
  assign rd_in_range   = 32'(rd_blk)   < 32'(NUM_BLOCKS);
  assign wr_in_range   = 32'(wr_blk)   < 32'(NUM_BLOCKS);
  assign fill_in_range = 32'(fill_blk) < 32'(NUM_BLOCKS);

  // Single shared array write port: CPU in IDLE, fill engine in FILL
  logic              mem_we;
  logic [BLK_W-1:0]  mem_wblk;
  logic [OFS_W-1:0]  mem_wofs;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_winj;
  logic [ENT_W-1:0]  mem_wentry;

  always_comb begin
    mem_we    = 1'b0;
    mem_wblk  = wr_blk;
    mem_wofs  = wr_word;
    mem_wdata = wr_data;
    mem_winj  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_en && wr_in_range) begin
        mem_we = 1'b1;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
        mem_winj = inj_perr;
`endif
      end
    end else if (fill_valid) begin
      mem_we    = 1'b1;
      mem_wblk  = blk_q;
      mem_wofs  = cnt_q;
      mem_wdata = fill_data;
    end
  end

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  // Stored bit makes {parity, data} even; inj_perr flips it for testing
  assign mem_wentry = {(^mem_wdata) ^ mem_winj, mem_wdata};
`else
  assign mem_wentry = mem_wdata;
  logic unused_winj;
  assign unused_winj = mem_winj;
`endif

  // Fill FSM next state
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (fill_start && fill_in_range) begin
        state_d = ST_FILL;
        blk_d   = fill_blk;
        cnt_d   = '0;
      end
    end else begin
      if (fill_valid) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (mem_we) begin
      mem_q[mem_wblk][mem_wofs] <= mem_wentry;
    end
  end

  // Read port samples the pre-edge contents, giving read-before-write
  logic [ENT_W-1:0] rd_entry;
  assign rd_entry = mem_q[rd_blk][rd_word];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_in_range ? rd_entry[WORD_W-1:0] : '0;
      end
    end
  end

`ifdef CACHE_DATA_ARRAY_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_perr_q <= 1'b0;
    end else begin
      rd_perr_q <= rd_en && rd_in_range && (^rd_entry);
    end
  end
  assign rd_perr = rd_perr_q;
`endif

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = done_q;

endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array
//   Scoreboard bench for cache_data_array with default parameters.
//   Reads push their expected data (and parity flag) with the cycle in
//   which rd_valid must appear; a negedge monitor pops and compares.
module tb_cache_data_array;

  localparam int unsigned NB  = 128;
  localparam int unsigned WPB = 8;
  localparam int unsigned WW  = 16;

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic [6:0]    rd_blk;
  logic [2:0]    rd_word;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [6:0]    wr_blk;
  logic [2:0]    wr_word;
  logic [WW-1:0] wr_data;
  logic          fill_start;
  logic [6:0]    fill_blk;
  logic          fill_valid;
  logic [WW-1:0] fill_data;
  logic          fill_busy;
  logic          fill_done;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
  logic          inj_perr;
  logic          rd_perr;
`endif

  cache_data_array #(
    .NUM_BLOCKS      (NB),
    .WORDS_PER_BLOCK (WPB),
    .WORD_W          (WW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_blk     (rd_blk),
    .rd_word    (rd_word),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_blk     (wr_blk),
    .wr_word    (wr_word),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_blk   (fill_blk),
    .fill_valid (fill_valid),
    .fill_data  (fill_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    ,
    .inj_perr   (inj_perr),
    .rd_perr    (rd_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [WW-1:0] data;
    logic          perr;
    int unsigned   due;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int unsigned done_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: rd_valid must appear exactly in the cycle the front entry is due
  always @(negedge clk) begin
    sb_t e;
    logic exp_v;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = sb.pop_front();
      check_eq("rd_data", {16'd0, rd_data}, {16'd0, e.data});
`ifdef CACHE_DATA_ARRAY_PARITY_EN
      check_eq("rd_perr", {31'd0, rd_perr}, {31'd0, e.perr});
`endif
    end
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    else begin
      check_eq("rd_perr_idle", {31'd0, rd_perr}, 32'd0);
    end
`endif
    if (fill_done === 1'b1) done_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_en      = 1'b0;
    rd_blk     = '0;
    rd_word    = '0;
    wr_en      = 1'b0;
    wr_blk     = '0;
    wr_word    = '0;
    wr_data    = '0;
    fill_start = 1'b0;
    fill_blk   = '0;
    fill_valid = 1'b0;
    fill_data  = '0;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    inj_perr   = 1'b0;
`endif
  endtask

  // Drive a read for the coming edge and queue its expected result
  task automatic push_rd(input int unsigned b, input int unsigned w,
                         input logic [WW-1:0] d, input logic p);
    sb_t e;
    rd_en   = 1'b1;
    rd_blk  = 7'(b);
    rd_word = 3'(w);
    e.data  = d;
    e.perr  = p;
    e.due   = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic read_chk(input int unsigned b, input int unsigned w, input logic [WW-1:0] d);
    push_rd(b, w, d, 1'b0);
    step();
    rd_en = 1'b0;
  endtask

  task automatic cpu_write(input int unsigned b, input int unsigned w,
                           input logic [WW-1:0] d, input logic inj);
    wr_en   = 1'b1;
    wr_blk  = 7'(b);
    wr_word = 3'(w);
    wr_data = d;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    inj_perr = inj;
`endif
    step();
    wr_en = 1'b0;
`ifdef CACHE_DATA_ARRAY_PARITY_EN
    inj_perr = 1'b0;
`else
    if (inj) ;
`endif
  endtask

  task automatic fill_beat(input logic [WW-1:0] d);
    fill_valid = 1'b1;
    fill_data  = d;
    step();
    fill_valid = 1'b0;
  endtask

  int unsigned done_base;

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, fill_busy}, 32'd0);
    check_eq("rst_done", {31'd0, fill_done}, 32'd0);

    // Basic reads and writes
    read_chk(5, 3, 16'h0000);
    cpu_write(127, 7, 16'hBEEF, 1'b0);
    read_chk(127, 7, 16'hBEEF);
    push_rd(127, 7, 16'hBEEF, 1'b0);
    wr_en = 1'b1; wr_blk = 7'd127; wr_word = 3'd7; wr_data = 16'h1234;
    step();
    clear_inputs();
    read_chk(127, 7, 16'h1234);
    cpu_write(3, 0, 16'h3333, 1'b0);

    // Fill blk 10 with a two-cycle stall; beat alongside fill_start is ignored
    done_base  = done_pulses;
    fill_start = 1'b1; fill_blk = 7'd10;
    fill_valid = 1'b1; fill_data = 16'hDEAD;
    step();
    clear_inputs();
    check_eq("fill_busy_start", {31'd0, fill_busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wr_en = 1'b1; wr_blk = 7'd10; wr_word = 3'd0; wr_data = 16'hFFFF;
        fill_start = 1'b1; fill_blk = 7'd20;
        step();
        clear_inputs();
        read_chk(3, 0, 16'h3333);
      end
      check_eq($sformatf("fill_busy_beat%0d", i), {31'd0, fill_busy}, 32'd1);
      check_eq($sformatf("fill_done_beat%0d", i), {31'd0, fill_done}, 32'd0);
      fill_beat(16'hA000 + 16'(i));
    end
    check_eq("fill_done_pulse", {31'd0, fill_done}, 32'd1);
    check_eq("fill_busy_end", {31'd0, fill_busy}, 32'd0);
    step();
    check_eq("fill_done_clear", {31'd0, fill_done}, 32'd0);
    check_eq("fill_busy_stays", {31'd0, fill_busy}, 32'd0);
    check_eq("fill_done_count", done_pulses - done_base, 32'd1);
    for (int w = 0; w < 8; w++) read_chk(10, w, 16'hA000 + 16'(w));
    read_chk(20, 0, 16'h0000);

    // Reset in the middle of a fill
    done_base  = done_pulses;
    fill_start = 1'b1; fill_blk = 7'd10;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) fill_beat(16'hB000 + 16'(i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_fill_busy", {31'd0, fill_busy}, 32'd0);
    check_eq("rst_fill_done", {31'd0, fill_done}, 32'd0);
    read_chk(10, 0, 16'h0000);
    read_chk(127, 7, 16'h0000);
    read_chk(3, 0, 16'h0000);
    check_eq("rst_done_count", done_pulses - done_base, 32'd0);

    // CPU write alongside fill_start, then back-to-back fills
    done_base  = done_pulses;
    wr_en = 1'b1; wr_blk = 7'd50; wr_word = 3'd2; wr_data = 16'h5555;
    fill_start = 1'b1; fill_blk = 7'd11;
    step();
    clear_inputs();
    check_eq("fill11_busy", {31'd0, fill_busy}, 32'd1);
    for (int i = 0; i < 8; i++) fill_beat(16'hC000 + 16'(i));
    check_eq("fill11_done", {31'd0, fill_done}, 32'd1);
    fill_start = 1'b1; fill_blk = 7'd12;
    step();
    clear_inputs();
    check_eq("fill12_busy", {31'd0, fill_busy}, 32'd1);
    check_eq("fill12_done_low", {31'd0, fill_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) push_rd(12, 1, 16'hD001, 1'b0);
      fill_beat(16'hD000 + 16'(i));
      rd_en = 1'b0;
    end
    check_eq("fill12_done", {31'd0, fill_done}, 32'd1);
    step();
    check_eq("b2b_done_count", done_pulses - done_base, 32'd2);
    read_chk(50, 2, 16'h5555);
    read_chk(11, 0, 16'hC000);
    read_chk(11, 7, 16'hC007);
    read_chk(12, 0, 16'hD000);
    read_chk(12, 7, 16'hD007);

`ifdef CACHE_DATA_ARRAY_PARITY_EN
    cpu_write(60, 0, 16'h0001, 1'b1);
    push_rd(60, 0, 16'h0001, 1'b1);
    step();
    rd_en = 1'b0;
    cpu_write(60, 0, 16'h0001, 1'b0);
    push_rd(60, 0, 16'h0001, 1'b0);
    step();
    rd_en = 1'b0;
`endif

    repeat (3) step();
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised cache data store: NUM_BLOCKS blocks of WORDS_PER_BLOCK words, each WORD_W bits.
- Replaces one-hot block/word enables and tri-state output with binary indices and a registered read port.
- Adds a block-fill engine that streams a whole line from the memory side, one word per valid beat, while the CPU port keeps reading.
- Sits between the cache controller (CPU side) and the memory interface (fill side).

Parameters:
- NUM_BLOCKS, 128, number of cache blocks; any value >= 2.
- WORDS_PER_BLOCK, 8, words per block; power of two, >= 2.
- WORD_W, 16, bits per word.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset.
- rd_en  in  1  read request.
- rd_blk  in  $clog2(NUM_BLOCKS)  read block index.
- rd_word  in  $clog2(WORDS_PER_BLOCK)  read word offset.
- rd_data  out  WORD_W  registered read data.
- rd_valid  out  1  rd_data valid; one cycle after rd_en.
- wr_en  in  1  CPU single-word write.
- wr_blk  in  $clog2(NUM_BLOCKS)  write block index.
- wr_word  in  $clog2(WORDS_PER_BLOCK)  write word offset.
- wr_data  in  WORD_W  write data.
- fill_start  in  1  begin line fill.
- fill_blk  in  $clog2(NUM_BLOCKS)  block to fill; sampled with fill_start.
- fill_valid  in  1  fill_data beat valid.
- fill_data  in  WORD_W  fill word.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill beat is written.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. When rst is sampled high:
  - all storage is cleared to 0;
  - rd_data=0, rd_valid=0;
  - fill_busy=0, fill_done=0;
  - FSM=IDLE, beat counter=0.
- Reset mid-fill aborts the fill; partial contents are cleared with the rest of the array.
- Read:
  - rd_en at edge N gives rd_data = mem[rd_blk][rd_word] after edge N, rd_valid=1 for that one cycle.
  - Read-before-write: a read and a write to the same word on the same edge return the old value.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
  - Reads are always serviced, including reads of the block being filled (returns whatever that word currently holds).
- CPU write: when wr_en=1 and FSM=IDLE, mem[wr_blk][wr_word] <= wr_data at the edge. When FSM=FILL, wr_en is ignored and nothing is stored.
- Out-of-range block index (>= NUM_BLOCKS):
  - writes and fill_start are ignored;
  - reads return 0 with rd_valid=1.
- FSM:
  - IDLE: fill_start=1 with an in-range fill_blk latches the block, clears the counter and goes to FILL. fill_busy=1 from the next cycle. fill_valid in the same cycle as fill_start is ignored.
  - FILL: each edge with fill_valid=1 writes mem[latched_blk][counter] <= fill_data and increments the counter. Words fill sequentially from 0 to WORDS_PER_BLOCK-1. fill_valid=0 stalls without limit.
  - FILL, last beat (counter=WORDS_PER_BLOCK-1 with fill_valid): writes the word, wraps the counter to 0 and goes to IDLE. fill_done=1 and fill_busy=0 in the following cycle.
  - fill_start while in FILL is ignored.
- Back-to-back fills: fill_start is accepted in the cycle fill_done is high, because the FSM is already IDLE.
- If wr_en and fill_start are high on the same edge in IDLE: the CPU write is performed, then the fill begins.

Optional Feature:
- Macro: CACHE_DATA_ARRAY_PARITY_EN.
- When defined:
  - each word stores an extra even-parity bit, computed on every CPU and fill write;
  - adds output port rd_perr (1 bit), registered alongside rd_data: 1 when the stored parity does not match the stored data;
  - rd_perr is reset to 0 and is 0 whenever rd_valid=0;
  - adds input port inj_perr (1 bit): on a CPU write it inverts the stored parity bit, for test use.
- When undefined: no parity storage and no rd_perr or inj_perr ports; behaviour is otherwise identical.

Test Plan:
- Reset, then rd_en with blk=5, word=3 -> next cycle rd_valid=1, rd_data=0x0000.
- wr_en with blk=127, word=7, data=0xBEEF; next cycle rd_en at same address -> rd_data=0xBEEF. Same-edge read and write of 0x1234 to that word -> read returns 0xBEEF, following read returns 0x1234.
- fill_start with blk=10, then 8 beats 0xA000..0xA007 with fill_valid deasserted for 2 cycles mid-burst -> fill_done pulses once after the 8th beat, fill_busy falls. Reads of words 0..7 return 0xA000..0xA007.
- During the fill of blk 10:
  - wr_en to blk 10 word 0 with 0xFFFF -> ignored, word reads 0xA000 after the fill;
  - a second fill_start -> ignored;
  - a read of blk 3 is serviced normally.
- Assert rst after 4 fill beats -> fill_busy=0, no fill_done, blk 10 word 0 reads 0. A new fill is accepted afterwards.
- With CACHE_DATA_ARRAY_PARITY_EN: write 0x0001 with inj_perr=1 -> read gives rd_perr=1. Rewrite with inj_perr=0 -> rd_perr=0.
